// File: rtl/gato_pkg.sv
// Shared types and board geometry for the tic-tac-toe CPU opponent.
package gato_pkg;

  typedef logic [3:0] casilla_t;

  typedef enum logic [2:0] {
    StIdle,
    StPensar,
    StPasoAlto,
    StPasoBajo,
    StConfirmar,
    StEsperar
  } estado_cpu_t;

  // Rows, columns, main diagonal, anti-diagonal; search order matters.
  localparam casilla_t LINEAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  localparam casilla_t PREFERENCIA [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  // Returns {found, cell}: free cell of the first line holding two marks.
  // Scanned last-to-first so the lowest-numbered matching line wins.
  function automatic logic [4:0] buscar_linea(logic [8:0] marcas, logic [8:0] libre);
    logic [4:0] r;
    casilla_t a, b, c;
    r = '0;
    for (int l = 7; l >= 0; l--) begin
      a = LINEAS[l][0];
      b = LINEAS[l][1];
      c = LINEAS[l][2];
      if (marcas[a] && marcas[b] && libre[c]) r = {1'b1, c};
      if (marcas[a] && libre[b] && marcas[c]) r = {1'b1, b};
      if (libre[a] && marcas[b] && marcas[c]) r = {1'b1, a};
    end
    return r;
  endfunction

endpackage

// File: rtl/jugador_auto_if.sv
// Board/cursor/strobe bundle between the CPU opponent and the game logic.
interface jugador_auto_if;
  import gato_pkg::*;

  logic       turno_cpu;
  logic [8:0] x_ocupadas;
  logic [8:0] o_ocupadas;
  casilla_t   cursor;
  logic       movimiento;
  logic       seleccion;
  logic       ocupado_cpu;
  casilla_t   objetivo;
  logic       sin_jugada;

  modport master (
    input  turno_cpu, x_ocupadas, o_ocupadas, cursor,
    output movimiento, seleccion, ocupado_cpu, objetivo, sin_jugada
  );

  modport slave (
    output turno_cpu, x_ocupadas, o_ocupadas, cursor,
    input  movimiento, seleccion, ocupado_cpu, objetivo, sin_jugada
  );
endinterface

// File: rtl/jugador_auto_elegir_casilla.sv
// Combinational target picker. JUGADOR_AUTO_WIN_BLOCK_EN adds win/block search
// ahead of the fixed preference order.
module elegir_casilla
  import gato_pkg::*;
(
  input  logic [8:0] propias,
  input  logic [8:0] rivales,
  output casilla_t   casilla,
  output logic       hay_libre
);

  logic [8:0] libre;
`ifdef JUGADOR_AUTO_WIN_BLOCK_EN
  logic [4:0] victoria;
  logic [4:0] bloqueo;
`endif

  always_comb begin
    libre     = ~(propias | rivales);
    hay_libre = |libre;
    casilla   = '0;
    for (int i = 8; i >= 0; i--) begin
      if (libre[PREFERENCIA[i]]) casilla = PREFERENCIA[i];
    end
`ifdef JUGADOR_AUTO_WIN_BLOCK_EN
    bloqueo  = buscar_linea(rivales, libre);
    victoria = buscar_linea(propias, libre);
    if (bloqueo[4])  casilla = bloqueo[3:0];
    if (victoria[4]) casilla = victoria[3:0];
`endif
  end

endmodule

// File: rtl/jugador_auto.sv
// CPU opponent: picks a cell, steps the shared cursor with movimiento pulses
// and confirms with seleccion. Strategy depth set by JUGADOR_AUTO_WIN_BLOCK_EN.
module jugador_auto
  import gato_pkg::*;
#(
  parameter bit          CPU_ES_O  = 1'b1,
  parameter int unsigned PULSE_W   = 2,
  parameter int unsigned MAX_PASOS = 9
) (
  input logic            clk,
  input logic            rst,
  jugador_auto_if.master bus
);

  localparam int unsigned CW = $clog2(PULSE_W) + 1;
  localparam int unsigned PW = $clog2(MAX_PASOS + 1);

  estado_cpu_t   estado_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pasos_q;

  logic [8:0] propias;
  logic [8:0] rivales;
  casilla_t   eleccion;
  logic       hay_libre;
  logic       objetivo_libre;
  logic       abortable;
  logic       ultimo_ciclo;

  assign propias = CPU_ES_O ? bus.o_ocupadas : bus.x_ocupadas;
  assign rivales = CPU_ES_O ? bus.x_ocupadas : bus.o_ocupadas;

  elegir_casilla u_elegir (
    .propias   (propias),
    .rivales   (rivales),
    .casilla   (eleccion),
    .hay_libre (hay_libre)
  );

  assign objetivo_libre = (bus.objetivo <= 4'd8) &&
                          !(bus.x_ocupadas[bus.objetivo] || bus.o_ocupadas[bus.objetivo]);
  assign abortable      = (estado_q == StPensar) || (estado_q == StPasoAlto) ||
                          (estado_q == StPasoBajo) || (estado_q == StConfirmar);
  assign ultimo_ciclo   = (cnt_q == CW'(PULSE_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q        <= StIdle;
      cnt_q           <= '0;
      pasos_q         <= '0;
      bus.movimiento  <= 1'b0;
      bus.seleccion   <= 1'b0;
      bus.ocupado_cpu <= 1'b0;
      bus.objetivo    <= '0;
      bus.sin_jugada  <= 1'b0;
    end else begin
      bus.seleccion  <= 1'b0;
      bus.sin_jugada <= 1'b0;
      if (abortable && !bus.turno_cpu) begin
        // Turn withdrawn mid-move: abandon without confirming.
        estado_q        <= StIdle;
        bus.movimiento  <= 1'b0;
        bus.ocupado_cpu <= 1'b0;
      end else begin
        unique case (estado_q)
          StIdle: begin
            if (bus.turno_cpu) begin
              estado_q        <= StPensar;
              bus.ocupado_cpu <= 1'b1;
            end
          end
          StPensar: begin
            bus.objetivo <= eleccion;
            pasos_q      <= '0;
            cnt_q        <= '0;
            if (!hay_libre) begin
              bus.sin_jugada <= 1'b1;
              estado_q       <= StEsperar;
            end else if (bus.cursor == eleccion) begin
              estado_q <= StConfirmar;
            end else begin
              bus.movimiento <= 1'b1;
              estado_q       <= StPasoAlto;
            end
          end
          StPasoAlto: begin
            if (ultimo_ciclo) begin
              cnt_q          <= '0;
              bus.movimiento <= 1'b0;
              pasos_q        <= pasos_q + 1'b1;
              estado_q       <= StPasoBajo;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StPasoBajo: begin
            if (ultimo_ciclo) begin
              cnt_q <= '0;
              if (bus.cursor == bus.objetivo) begin
                estado_q <= StConfirmar;
              end else if (pasos_q == PW'(MAX_PASOS)) begin
                bus.sin_jugada <= 1'b1;
                estado_q       <= StEsperar;
              end else begin
                bus.movimiento <= 1'b1;
                estado_q       <= StPasoAlto;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StConfirmar: begin
            // The rival may have taken the cell while we were stepping.
            if (objetivo_libre) begin
              bus.seleccion <= 1'b1;
              estado_q      <= StEsperar;
            end else begin
              estado_q <= StPensar;
            end
          end
          StEsperar: begin
            if (!bus.turno_cpu) begin
              estado_q        <= StIdle;
              bus.ocupado_cpu <= 1'b0;
            end
          end
          default: estado_q <= StIdle;
        endcase
      end
    end
  end

endmodule
